// File: rtl/ups_axi_regs.sv
// ups_axi_regs: parametrised AXI4-Lite register file with NREG RW control and NRO RO status words.
module ups_axi_regs #(
  parameter int NREG = 8,
  parameter int NRO = 4,
  parameter int AI = 4,
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] ctrl [NREG-1:0],
  output logic [NREG-1:0] wr_pulse,
  input  logic [31:0] status [NRO-1:0],
  output logic [NRO-1:0] rd_pulse,
  input  logic [31:0] ca4l_araddr,
  input  logic        ca4l_arvalid,
  output logic        ca4l_arready,
  output logic [31:0] ca4l_rdata,
  output logic [1:0]  ca4l_rresp,
  output logic        ca4l_rvalid,
  input  logic        ca4l_rready,
  input  logic [31:0] ca4l_awaddr,
  input  logic        ca4l_awvalid,
  output logic        ca4l_awready,
  input  logic [31:0] ca4l_wdata,
  input  logic [3:0]  ca4l_wstrb,
  input  logic        ca4l_wvalid,
  output logic        ca4l_wready,
  output logic [1:0]  ca4l_bresp,
  output logic        ca4l_bvalid,
  input  logic        ca4l_bready
);
  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  if (NREG + NRO > 2**AI) begin : g_bad_cfg
    $error("ups_axi_regs: NREG+NRO exceeds 2**AI");
  end
  wstate_t wst, wst_n;
  rstate_t rs, rs_n;
  logic aw_got, w_got, aw_got_n, w_got_n;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic w_ctrl, r_err;
  logic [AI-1:0] w_idx, ar_idx;
  logic [31:0] wdata_q, r_data;
  logic [3:0] wstrb_q;
  logic [NRO-1:0] r_pulse;
  logic unused;
  assign unused = ^{ca4l_araddr[31:AI+2], ca4l_araddr[1:0], ca4l_awaddr[31:AI+2], ca4l_awaddr[1:0]};
  assign ar_idx = ca4l_araddr[AI+1:2];
  always_comb begin
    aw_hs = ca4l_awvalid && ca4l_awready;
    w_hs = ca4l_wvalid && ca4l_wready;
    b_hs = ca4l_bvalid && ca4l_bready;
    ar_hs = ca4l_arvalid && ca4l_arready;
    r_hs = ca4l_rvalid && ca4l_rready;
    aw_got_n = !b_hs && (aw_got || aw_hs);
    w_got_n = !b_hs && (w_got || w_hs);
    wst_n = (wst == W_IDLE) ? ((aw_got && w_got) ? W_EXEC : W_IDLE) :
            (wst == W_EXEC) ? W_RESP : (b_hs ? W_IDLE : W_RESP);
    rs_n = (rs == R_IDLE) ? (ar_hs ? R_DATA : R_IDLE) : (r_hs ? R_IDLE : R_DATA);
  end
  // Write-side decode; the pulse fires on any ctrl hit, even with an empty strobe.
  always_comb begin
    w_ctrl = 1'b0;
    wr_pulse = '0;
    for (int i = 0; i < NREG; i++)
      if (w_idx == AI'(i)) begin
        w_ctrl = 1'b1;
        wr_pulse[i] = (wst == W_EXEC);
      end
  end
  always_comb begin
    r_data = '0;
    r_err = 1'b1;
    r_pulse = '0;
    for (int i = 0; i < NREG; i++)
      if (ar_idx == AI'(i)) begin
        r_data = ctrl[i];
        r_err = 1'b0;
      end
    for (int j = 0; j < NRO; j++)
      if (ar_idx == AI'(NREG + j)) begin
        r_data = status[j];
        r_err = 1'b0;
        r_pulse[j] = 1'b1;
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wst <= W_IDLE;
      rs <= R_IDLE;
    end else begin
      wst <= wst_n;
      rs <= rs_n;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      aw_got <= 1'b0;
      w_got <= 1'b0;
      ca4l_awready <= 1'b0;
      ca4l_wready <= 1'b0;
      ca4l_bvalid <= 1'b0;
      ca4l_bresp <= 2'b00;
      w_idx <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      for (int i = 0; i < NREG; i++) ctrl[i] <= RST_VAL;
    end else begin
      aw_got <= aw_got_n;
      w_got <= w_got_n;
      ca4l_awready <= (wst_n == W_IDLE) && !aw_got_n;
      ca4l_wready <= (wst_n == W_IDLE) && !w_got_n;
      ca4l_bvalid <= (wst_n == W_RESP);
      if (aw_hs) w_idx <= ca4l_awaddr[AI+1:2];
      if (w_hs) begin
        wdata_q <= ca4l_wdata;
        wstrb_q <= ca4l_wstrb;
      end
      if (wst == W_EXEC) ca4l_bresp <= w_ctrl ? 2'b00 : 2'b10;
      for (int i = 0; i < NREG; i++)
        for (int k = 0; k < 4; k++)
          if (wr_pulse[i] && wstrb_q[k]) ctrl[i][8*k +: 8] <= wdata_q[8*k +: 8];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ca4l_arready <= 1'b0;
      ca4l_rvalid <= 1'b0;
      ca4l_rdata <= '0;
      ca4l_rresp <= 2'b00;
      rd_pulse <= '0;
    end else begin
      ca4l_arready <= (rs_n == R_IDLE);
      ca4l_rvalid <= (rs_n == R_DATA);
      rd_pulse <= ar_hs ? r_pulse : '0;
      if (ar_hs) begin
        ca4l_rdata <= r_data;
        ca4l_rresp <= r_err ? 2'b10 : 2'b00;
      end
    end
endmodule

// File: tb/tb_ups_axi_regs.sv
// tb_ups_axi_regs: directed checks of ups_axi_regs with default parameters (8 RW, 4 RO, AI=4).
module tb_ups_axi_regs;
  localparam int NREG = 8;
  localparam int NRO = 4;
  logic clk = 0, rst_n = 0;
  logic [31:0] ctrl [NREG-1:0];
  logic [NREG-1:0] wr_pulse;
  logic [31:0] status [NRO-1:0];
  logic [NRO-1:0] rd_pulse;
  logic [31:0] ca4l_araddr = 0, ca4l_rdata, ca4l_awaddr = 0, ca4l_wdata = 0;
  logic ca4l_arvalid = 0, ca4l_arready, ca4l_rvalid, ca4l_rready = 0;
  logic ca4l_awvalid = 0, ca4l_awready, ca4l_wvalid = 0, ca4l_wready;
  logic ca4l_bvalid, ca4l_bready = 0;
  logic [1:0] ca4l_rresp, ca4l_bresp;
  logic [3:0] ca4l_wstrb = 0;
  int checks = 0, errors = 0;
  int wp_cnt [NREG] = '{default: 0};
  int rp_cnt [NRO] = '{default: 0};
  logic [31:0] exp_ctrl [NREG] = '{default: 32'h0};

  ups_axi_regs #(.NREG(NREG), .NRO(NRO), .AI(4), .RST_VAL(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .wr_pulse(wr_pulse), .status(status), .rd_pulse(rd_pulse),
    .ca4l_araddr(ca4l_araddr), .ca4l_arvalid(ca4l_arvalid), .ca4l_arready(ca4l_arready),
    .ca4l_rdata(ca4l_rdata), .ca4l_rresp(ca4l_rresp), .ca4l_rvalid(ca4l_rvalid), .ca4l_rready(ca4l_rready),
    .ca4l_awaddr(ca4l_awaddr), .ca4l_awvalid(ca4l_awvalid), .ca4l_awready(ca4l_awready),
    .ca4l_wdata(ca4l_wdata), .ca4l_wstrb(ca4l_wstrb), .ca4l_wvalid(ca4l_wvalid), .ca4l_wready(ca4l_wready),
    .ca4l_bresp(ca4l_bresp), .ca4l_bvalid(ca4l_bvalid), .ca4l_bready(ca4l_bready));

  always #5 clk = ~clk;
  always @(negedge clk) begin
    for (int i = 0; i < NREG; i++) wp_cnt[i] += int'(wr_pulse[i]);
    for (int j = 0; j < NRO; j++) rp_cnt[j] += int'(rd_pulse[j]);
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic int wp_total();
    int s = 0;
    for (int i = 0; i < NREG; i++) s += wp_cnt[i];
    return s;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit hold,
                          output logic [1:0] resp);
    int n = 0;
    ca4l_awaddr = a; ca4l_awvalid = 1; ca4l_wdata = d; ca4l_wstrb = s; ca4l_wvalid = 1;
    while ((ca4l_awvalid || ca4l_wvalid) && n < 20) begin
      bit af, wf;
      af = ca4l_awvalid && ca4l_awready;
      wf = ca4l_wvalid && ca4l_wready;
      @(negedge clk);
      if (af) ca4l_awvalid = 0;
      if (wf) ca4l_wvalid = 0;
      n++;
    end
    while (!ca4l_bvalid && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (!ca4l_bvalid) begin
      errors++;
      $display("FAIL write_timeout addr %h bvalid 0 required 1", a);
      ca4l_awvalid = 0; ca4l_wvalid = 0;
    end
    resp = ca4l_bresp;
    if (!hold && ca4l_bvalid) begin ca4l_bready = 1; @(negedge clk); ca4l_bready = 0; end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp, output int lat);
    int n = 0;
    ca4l_araddr = a; ca4l_arvalid = 1;
    while (ca4l_arvalid && n < 20) begin
      bit f;
      f = ca4l_arvalid && ca4l_arready;
      @(negedge clk);
      if (f) ca4l_arvalid = 0;
      n++;
    end
    lat = 1;
    while (!ca4l_rvalid && lat < 20) begin @(negedge clk); lat++; end
    checks++;
    if (!ca4l_rvalid) begin
      errors++;
      $display("FAIL read_timeout addr %h rvalid 0 required 1", a);
      ca4l_arvalid = 0;
    end
    d = ca4l_rdata; resp = ca4l_rresp;
    ca4l_rready = 1; @(negedge clk); ca4l_rready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ca4l_awready, ca4l_wready, ca4l_arready, ca4l_bvalid, ca4l_rvalid, ca4l_bresp, ca4l_rresp,
         ca4l_rdata, wr_pulse, rd_pulse} !== '0) begin
      errors++;
      $display("FAIL reset_outputs aw/w/ar ready %b%b%b bvalid %b rvalid %b required all 0",
               ca4l_awready, ca4l_wready, ca4l_arready, ca4l_bvalid, ca4l_rvalid);
    end
    for (int i = 0; i < NREG; i++) begin
      checks++;
      if (ctrl[i] !== 32'h0) begin errors++; $display("FAIL reset_ctrl[%0d] got %h required 00000000", i, ctrl[i]); end
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({ca4l_awready, ca4l_wready, ca4l_arready} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_reset got %b required 111", {ca4l_awready, ca4l_wready, ca4l_arready});
    end
  endtask

  task automatic test_basic();
    logic [1:0] r; logic [31:0] d; int lat;
    int c3 = wp_cnt[3], t0 = wp_total();
    do_write(32'h0000_000C, 32'hA5A5_1234, 4'hF, 0, r);
    exp_ctrl[3] = 32'hA5A5_1234;
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL basic_bresp got %b required 00", r); end
    checks++;
    if (wp_cnt[3] - c3 != 1 || wp_total() - t0 != 1) begin
      errors++; $display("FAIL basic_wr_pulse idx3 cycles %0d total %0d required 1 1", wp_cnt[3] - c3, wp_total() - t0);
    end
    checks++;
    if (ctrl[3] !== 32'hA5A5_1234) begin errors++; $display("FAIL basic_ctrl3 got %h required a5a51234", ctrl[3]); end
    do_read(32'h0000_000C, d, r, lat);
    checks++;
    if (d !== 32'hA5A5_1234 || r !== 2'b00 || lat != 1) begin
      errors++; $display("FAIL basic_read got %h resp %b lat %0d required a5a51234 00 1", d, r, lat);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r; int c0;
    do_write(32'h0, 32'h1122_3344, 4'hF, 0, r);
    do_write(32'h0, 32'hFFFF_FFFF, 4'b0101, 0, r);
    checks++;
    if (ctrl[0] !== 32'h11FF_33FF || r !== 2'b00) begin
      errors++; $display("FAIL strobe_0101 got %h resp %b required 11ff33ff 00", ctrl[0], r);
    end
    c0 = wp_cnt[0];
    do_write(32'h0, 32'h0000_0000, 4'b0000, 0, r);
    checks++;
    if (ctrl[0] !== 32'h11FF_33FF || wp_cnt[0] - c0 != 1) begin
      errors++; $display("FAIL strobe_none got %h pulses %0d required 11ff33ff 1", ctrl[0], wp_cnt[0] - c0);
    end
    do_write(32'h0, 32'hABCD_EF01, 4'b1000, 0, r);
    exp_ctrl[0] = 32'hABFF_33FF;
    checks++;
    if (ctrl[0] !== 32'hABFF_33FF) begin errors++; $display("FAIL strobe_1000 got %h required abff33ff", ctrl[0]); end
  endtask

  task automatic test_order();
    int n;
    ca4l_wdata = 32'h5555_AAAA; ca4l_wstrb = 4'hF; ca4l_wvalid = 1;
    @(negedge clk);
    ca4l_wvalid = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (ca4l_wready !== 1'b0 || ca4l_awready !== 1'b1 || ca4l_bvalid !== 1'b0) begin
      errors++; $display("FAIL wfirst_wait wready %b awready %b bvalid %b required 0 1 0", ca4l_wready, ca4l_awready, ca4l_bvalid);
    end
    ca4l_awaddr = 32'h0000_0014; ca4l_awvalid = 1;
    @(negedge clk);
    ca4l_awvalid = 0;
    n = 0;
    while (!ca4l_bvalid && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (ca4l_bvalid !== 1'b1 || ca4l_bresp !== 2'b00 || ca4l_wready !== 1'b0 || ca4l_awready !== 1'b0) begin
      errors++; $display("FAIL wfirst_resp bvalid %b bresp %b wready %b awready %b required 1 00 0 0",
                         ca4l_bvalid, ca4l_bresp, ca4l_wready, ca4l_awready);
    end
    ca4l_bready = 1; @(negedge clk); ca4l_bready = 0;
    exp_ctrl[5] = 32'h5555_AAAA;
    checks++;
    if (ctrl[5] !== 32'h5555_AAAA || ca4l_wready !== 1'b1 || ca4l_awready !== 1'b1) begin
      errors++; $display("FAIL wfirst_commit ctrl5 %h readies %b%b required 5555aaaa 11", ctrl[5], ca4l_awready, ca4l_wready);
    end
    // high address bits and byte offset alias onto idx 6
    ca4l_awaddr = 32'hFFFF_FF1B; ca4l_awvalid = 1;
    @(negedge clk);
    ca4l_awvalid = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (ca4l_awready !== 1'b0 || ca4l_wready !== 1'b1 || ca4l_bvalid !== 1'b0) begin
      errors++; $display("FAIL awfirst_wait awready %b wready %b bvalid %b required 0 1 0", ca4l_awready, ca4l_wready, ca4l_bvalid);
    end
    ca4l_wdata = 32'h0BAD_F00D; ca4l_wstrb = 4'hF; ca4l_wvalid = 1;
    @(negedge clk);
    ca4l_wvalid = 0;
    n = 0;
    while (!ca4l_bvalid && n < 10) begin @(negedge clk); n++; end
    ca4l_bready = 1; @(negedge clk); ca4l_bready = 0;
    exp_ctrl[6] = 32'h0BAD_F00D;
    checks++;
    if (ctrl[6] !== 32'h0BAD_F00D) begin errors++; $display("FAIL awfirst_commit ctrl6 got %h required 0badf00d", ctrl[6]); end
  endtask

  task automatic test_status();
    logic [31:0] d; logic [1:0] r; int lat;
    int p0 = rp_cnt[0], p1 = rp_cnt[1], p3 = rp_cnt[3];
    status[0] = 32'hCAFE_0001; status[1] = 32'h0; status[2] = 32'h0; status[3] = 32'h1234_5678;
    ca4l_araddr = 32'h0000_0020; ca4l_arvalid = 1;
    @(negedge clk);
    ca4l_arvalid = 0;
    status[0] = 32'h0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({ca4l_rvalid, ca4l_rdata, ca4l_rresp, ca4l_arready} !== {1'b1, 32'hCAFE_0001, 2'b00, 1'b0}) begin
        errors++; $display("FAIL status_hold cycle %0d rvalid %b rdata %h rresp %b arready %b required 1 cafe0001 00 0",
                           c, ca4l_rvalid, ca4l_rdata, ca4l_rresp, ca4l_arready);
      end
      @(negedge clk);
    end
    ca4l_rready = 1; @(negedge clk); ca4l_rready = 0;
    checks++;
    if (ca4l_rvalid !== 1'b0 || ca4l_arready !== 1'b1 || rp_cnt[0] - p0 != 1 || rp_cnt[1] != p1) begin
      errors++; $display("FAIL status_done rvalid %b arready %b rd_pulse0 %0d required 0 1 1",
                         ca4l_rvalid, ca4l_arready, rp_cnt[0] - p0);
    end
    do_read(32'h0000_002C, d, r, lat);
    checks++;
    if (d !== 32'h1234_5678 || r !== 2'b00 || rp_cnt[3] - p3 != 1) begin
      errors++; $display("FAIL status3_read got %h resp %b pulses %0d required 12345678 00 1", d, r, rp_cnt[3] - p3);
    end
  endtask

  task automatic test_errors();
    logic [1:0] r; logic [31:0] d; int lat;
    int t0 = wp_total();
    do_write(32'h0000_0024, 32'hDEAD_BEEF, 4'hF, 0, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL err_ro_bresp got %b required 10", r); end
    do_write(32'h0000_0030, 32'hDEAD_BEEF, 4'hF, 0, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL err_unmapped_bresp got %b required 10", r); end
    checks++;
    if (wp_total() != t0) begin errors++; $display("FAIL err_wr_pulse got %0d required 0", wp_total() - t0); end
    for (int i = 0; i < NREG; i++) begin
      checks++;
      if (ctrl[i] !== exp_ctrl[i]) begin errors++; $display("FAIL err_ctrl[%0d] got %h required %h", i, ctrl[i], exp_ctrl[i]); end
    end
    do_read(32'h0000_0030, d, r, lat);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL err_read12 got %h resp %b required 00000000 10", d, r); end
    do_read(32'h8000_003C, d, r, lat);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL err_read15 got %h resp %b required 00000000 10", d, r); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r; logic [31:0] d; int lat; bit seen = 0;
    do_write(32'h0000_0008, 32'h0000_0077, 4'hF, 1, r);
    #2 rst_n = 0;
    #1;
    checks++;
    if (ca4l_bvalid !== 1'b0) begin errors++; $display("FAIL mid_reset_bvalid got %b required 0", ca4l_bvalid); end
    for (int i = 0; i < NREG; i++) begin
      checks++;
      if (ctrl[i] !== 32'h0) begin errors++; $display("FAIL mid_reset_ctrl[%0d] got %h required 00000000", i, ctrl[i]); end
    end
    @(negedge clk);
    rst_n = 1;
    ca4l_bready = 1;
    repeat (4) begin @(negedge clk); seen |= ca4l_bvalid; end
    ca4l_bready = 0;
    checks++;
    if (seen) begin errors++; $display("FAIL mid_reset_stale_b got bvalid 1 required 0"); end
    do_write(32'h0000_0008, 32'h1357_9BDF, 4'hF, 0, r);
    do_read(32'h0000_0008, d, r, lat);
    checks++;
    if (d !== 32'h1357_9BDF || r !== 2'b00) begin errors++; $display("FAIL mid_reset_recover got %h resp %b required 13579bdf 00", d, r); end
  endtask

  initial begin
    for (int j = 0; j < NRO; j++) status[j] = 32'h0;
    test_reset();
    test_basic();
    test_strobe();
    test_order();
    test_status();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
